// File: rtl/irq_controller.sv
// Interrupt aggregator: latches pulse sources into active flags, arbitrates by
// per-source priority against the CPU level and drives a four-phase req/ack.
module irq_controller #(
  parameter logic [23:0] IRQ_PRI = 24'h002020,
  parameter logic [23:0] IRQ_ENA = 24'h002024,
  parameter logic [23:0] IRQ_ACT = 24'h002026
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_ce,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  input  logic [15:0] irq_in,
  input  logic [1:0]  cpu_ilevel,
  input  logic        irq_ack,
  output logic        irq_req,
  output logic [3:0]  irq_index,
  output logic [1:0]  irq_level
);

  // state  | meaning
  // S_IDLE | no request outstanding
  // S_REQ  | irq_req high, winner tracks the best candidate until ack
  // S_ACK  | CPU has acknowledged, waiting for irq_ack to drop
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

  state_t      state_q;
  logic [31:0] pri_q, pri_d;
  logic [15:0] ena_q, ena_d;
  logic [15:0] act_q, act_d;
  logic [15:0] act_clr;
  logic        irq_req_q;
  logic [3:0]  irq_index_q;
  logic [1:0]  irq_level_q;

  logic [23:0] pri_off, ena_off, act_off;
  logic        pri_hit, ena_hit, act_hit;

  logic        cand_valid;
  logic [3:0]  cand_idx;
  logic [1:0]  cand_lvl;

  // Reads have no side effects, so the strobe is not needed by the data path.
  logic unused_bus_read;
  assign unused_bus_read = bus_read;

  assign pri_off = bus_address_in - IRQ_PRI;
  assign ena_off = bus_address_in - IRQ_ENA;
  assign act_off = bus_address_in - IRQ_ACT;
  assign pri_hit = (pri_off < 24'd4);
  assign ena_hit = (ena_off < 24'd2);
  assign act_hit = (act_off < 24'd2);

  always_comb begin
    bus_data_out = 8'h00;
    if (pri_hit)      bus_data_out = pri_q[{pri_off[1:0], 3'b000} +: 8];
    else if (ena_hit) bus_data_out = ena_q[{ena_off[0], 3'b000} +: 8];
    else if (act_hit) bus_data_out = act_q[{act_off[0], 3'b000} +: 8];
  end

  // New pulses are OR-ed in after the write-1-to-clear so a same-cycle set wins.
  always_comb begin
    pri_d   = pri_q;
    ena_d   = ena_q;
    act_clr = 16'h0000;
    if (bus_write) begin
      if (pri_hit) pri_d[{pri_off[1:0], 3'b000} +: 8] = bus_data_in;
      if (ena_hit) ena_d[{ena_off[0], 3'b000} +: 8]   = bus_data_in;
      if (act_hit) act_clr[{act_off[0], 3'b000} +: 8] = bus_data_in;
    end
    act_d = (act_q & ~act_clr) | irq_in;
  end

  // Ascending scan with strict compare keeps the lowest index on equal priority.
  always_comb begin
    logic [1:0] src_pri;
    cand_valid = 1'b0;
    cand_idx   = 4'd0;
    cand_lvl   = 2'd0;
    for (int i = 0; i < 16; i++) begin
      src_pri = pri_q[2*i +: 2];
      if (act_q[i] && ena_q[i] && (src_pri > cpu_ilevel) &&
          (!cand_valid || (src_pri > cand_lvl))) begin
        cand_valid = 1'b1;
        cand_idx   = 4'(i);
        cand_lvl   = src_pri;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pri_q       <= 32'h0;
      ena_q       <= 16'h0;
      act_q       <= 16'h0;
      irq_req_q   <= 1'b0;
      irq_index_q <= 4'd0;
      irq_level_q <= 2'd0;
    end else if (clk_ce) begin
      pri_q <= pri_d;
      ena_q <= ena_d;
      act_q <= act_d;
      case (state_q)
        S_IDLE: begin
          if (cand_valid) begin
            state_q     <= S_REQ;
            irq_req_q   <= 1'b1;
            irq_index_q <= cand_idx;
            irq_level_q <= cand_lvl;
          end
        end
        S_REQ: begin
          if (irq_ack) begin
            state_q   <= S_ACK;
            irq_req_q <= 1'b0;
          end else if (!cand_valid) begin
            state_q   <= S_IDLE;
            irq_req_q <= 1'b0;
          end else begin
            irq_index_q <= cand_idx;
            irq_level_q <= cand_lvl;
          end
        end
        S_ACK: begin
          irq_req_q <= 1'b0;
          if (!irq_ack) state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          irq_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req   = irq_req_q;
  assign irq_index = irq_index_q;
  assign irq_level = irq_level_q;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt aggregator downstream of the timer and the other peripheral blocks.
- Latches single-cycle interrupt pulses into active flags and masks them with per-source enables.
- Arbitrates by 2-bit per-source priority against the CPU's current interrupt level.
- Presents one request to the CPU core over a four-phase req/ack handshake; exposes PRI/ENA/ACT registers on the shared byte bus.

Parameters:
- IRQ_PRI, 24'h002020, base of 4 priority bytes; byte k holds sources 4k..4k+3, source 4k+j at bits [2j+1:2j].
- IRQ_ENA, 24'h002024, base of 2 enable bytes; byte 0 = sources 7:0, byte 1 = sources 15:8.
- IRQ_ACT, 24'h002026, base of 2 active-flag bytes, same bit layout as ENA.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- clk_ce  input  1  clock enable; all state advances only when high
- bus_write  input  1  byte write strobe
- bus_read  input  1  byte read strobe (no side effects)
- bus_address_in  input  24  bus address
- bus_data_in  input  8  write data
- bus_data_out  output  8  read data, combinational
- irq_in  input  16  interrupt pulses; timer irqs[2:0] map to bits 2:0
- cpu_ilevel  input  2  CPU current interrupt level mask
- irq_ack  input  1  CPU acknowledge
- irq_req  output  1  interrupt request to CPU
- irq_index  output  4  winning source number
- irq_level  output  2  priority of winning source

Behaviour:
- Reset (reset_n low, async): PRI=0, ENA=0, ACT=0, state=IDLE, irq_req=0, irq_index=0, irq_level=0.
- Storage: pri[15:0][1:0], ena[15:0], act[15:0].
- All sequential updates on posedge clk gated by clk_ce.
- Register writes:
  - Take effect on the clk_ce cycle with bus_write high; no write latency stage.
  - PRI/ENA writes are plain byte stores.
  - ACT writes are write-1-to-clear per bit; writing 0 leaves the bit unchanged.
- Flag set: on each clk_ce, act[i] <= 1 when irq_in[i]=1, independent of ena/pri.
- Same-cycle set and clear on one bit: set wins, act[i]=1.
- Reads: bus_data_out returns the addressed PRI/ENA/ACT byte; 8'h00 for any other address.
- Candidate logic (combinational):
  - Source i is eligible when act[i] & ena[i] & pri[i]!=0 & pri[i] > cpu_ilevel.
  - The best candidate has the highest pri; on equal pri, the lowest index wins.
  - cand_valid = any eligible source.
- State machine (advances on clk_ce):
  - IDLE: irq_req=0. If cand_valid, latch irq_index/irq_level from the best candidate, set irq_req=1, go to REQ.
  - REQ: irq_req=1.
    - If irq_ack=1: go to ACK with irq_req=0; irq_index/irq_level are frozen.
    - Else if cand_valid=0 (flag cleared, source disabled, or cpu_ilevel raised): withdraw, irq_req=0, go to IDLE.
    - Else: re-latch irq_index/irq_level from the current best candidate, so a higher-priority arrival preempts before ack.
  - ACK: irq_req=0; wait for irq_ack=0, then go to IDLE. The earliest possible new request is the cycle after that.
- Acknowledge does not clear act; software clears it via ACT write-1.
  - A still-pending flag re-requests after ACK only if it remains eligible against the new cpu_ilevel.
- Latency: a pulse on irq_in at clk_ce cycle N sets act at edge N; irq_req rises at edge N+1 when eligible.
- irq_ack asserted while in IDLE is ignored.
- Reset mid-handshake returns to IDLE with irq_req=0 immediately (async).
- With clk_ce=0: state, flags and outputs hold; irq_in pulses in those cycles are not captured.

Test Plan:
- Single request: PRI[0]=8'h03, ENA0=8'h01, cpu_ilevel=0, pulse irq_in[0] -> act=16'h0001, irq_req high next clk_ce with irq_index=0, irq_level=3; ack -> irq_req low, ACK state; ack low -> IDLE, re-request because act still set; write ACT0=8'h01 -> act=0, no request.
- Priority and tie-break: sources 1 (pri 2), 2 (pri 2), 5 (pri 3) all enabled and pulsed the same cycle -> irq_index=5; after clearing 5 -> irq_index=1.
- Masking: source 3 pri 2, cpu_ilevel=2 -> no irq_req; drop cpu_ilevel to 1 -> irq_req, irq_level=2. Set ENA bit 0 -> no irq_req while act still 1.
- Preemption and withdraw: source 4 pri 1 in REQ, pulse source 6 pri 3 before ack -> irq_index changes 4->6 while irq_req stays high. Clear both act bits before ack -> irq_req drops, state returns to IDLE.
- Set/clear collision: pulse irq_in[7] in the same clk_ce cycle as an ACT0 write of 8'h80 -> act[7]=1. Readback of IRQ_ACT returns 8'h80; read of an unmapped address returns 8'h00.
- Async reset during REQ: reset_n low between clock edges -> irq_req=0 and all registers 0 before the next edge; clk_ce low during a pulse -> pulse not captured.
